orgate: RTL and testbench

ORGATE -- requirements
Module: orgate

---
 rtl/orgate.sv | 79 +++++++
 tb/tb_orgate.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/orgate.sv
// Registered bitwise OR of two operands, with summary flags (any/all bits set)
// and a population count, all captured in the same cycle as the result.
module orgate #(
   parameter int WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   input  logic                           in_valid,
   output logic [WIDTH-1:0]               c,
   output logic                           out_valid,
   output logic                           any_set,
   output logic                           all_set,
   output logic [$clog2(WIDTH+1)-1:0]     ones_cnt
);

   localparam int CW = $clog2(WIDTH + 1);

   // Sized so that a fully-set operand counts to WIDTH without wrapping.
   function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      n = {CW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         n = n + CW'(v[i]);
      end
      return n;
   endfunction

   logic [WIDTH-1:0] or_s;
   logic             any_s;
   logic             all_s;
   logic [CW-1:0]    cnt_s;

   logic [WIDTH-1:0] c_r;
   logic             out_valid_r;
   logic             any_set_r;
   logic             all_set_r;
   logic [CW-1:0]    ones_cnt_r;

   // Result and its summary values, evaluated from the live operands.
   always_comb begin
      or_s  = a | b;
      any_s = |or_s;
      all_s = &or_s;
      cnt_s = popcount(or_s);
   end

   // Capture register; reset wins over a simultaneous capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_r         <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         any_set_r   <= 1'b0;
         all_set_r   <= 1'b0;
         ones_cnt_r  <= {CW{1'b0}};
      end else begin
         out_valid_r <= in_valid;
         if (in_valid) begin
            c_r        <= or_s;
            any_set_r  <= any_s;
            all_set_r  <= all_s;
            ones_cnt_r <= cnt_s;
         end else begin
            c_r        <= c_r;
            any_set_r  <= any_set_r;
            all_set_r  <= all_set_r;
            ones_cnt_r <= ones_cnt_r;
         end
      end
   end

   assign c         = c_r;
   assign out_valid = out_valid_r;
   assign any_set   = any_set_r;
   assign all_set   = all_set_r;
   assign ones_cnt  = ones_cnt_r;

endmodule

// File: tb/tb_orgate.sv
// Self-checking bench for orgate: directed vector table, narrow-width sequence,
// and randomized traffic compared against a behavioural model.
module tb_orgate;

   logic        clk;
   logic        rst;
   logic [31:0] a, b;
   logic        in_valid;
   logic [31:0] c;
   logic        out_valid, any_set, all_set;
   logic [5:0]  ones_cnt;

   logic [3:0]  a4, b4;
   logic        in_valid4;
   logic [3:0]  c4;
   logic        out_valid4, any_set4, all_set4;
   logic [2:0]  ones_cnt4;

   int n_checks = 0;
   int n_fail   = 0;

   orgate #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
      .c(c), .out_valid(out_valid), .any_set(any_set), .all_set(all_set),
      .ones_cnt(ones_cnt)
   );

   orgate #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(in_valid4),
      .c(c4), .out_valid(out_valid4), .any_set(any_set4), .all_set(all_set4),
      .ones_cnt(ones_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        ov;
      logic        any;
      logic        all;
      int          cnt;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] ec, input logic eov,
                            input logic eany, input logic eall, input int ecnt);
      check({tag, ".c"},         longint'(c),         longint'(ec));
      check({tag, ".out_valid"}, longint'(out_valid), longint'(eov));
      check({tag, ".any_set"},   longint'(any_set),   longint'(eany));
      check({tag, ".all_set"},   longint'(all_set),   longint'(eall));
      check({tag, ".ones_cnt"},  longint'(ones_cnt),  longint'(ecnt));
   endtask

   logic [31:0] m_c;
   logic        m_ov;

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = 32'h0; b = 32'h0;
      a4 = 4'h0; b4 = 4'h0; in_valid4 = 1'b0;

      //          rst   iv    a             b             c             ov    any   all   cnt
      vecs[0]  = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 0};
      vecs[2]  = '{1'b0, 1'b1, 32'hffffffff, 32'h00000000, 32'hffffffff, 1'b1, 1'b1, 1'b1, 32};
      vecs[3]  = '{1'b0, 1'b1, 32'h00000000, 32'hffffffff, 32'hffffffff, 1'b1, 1'b1, 1'b1, 32};
      vecs[4]  = '{1'b0, 1'b1, 32'h007fa509, 32'hffffffff, 32'hffffffff, 1'b1, 1'b1, 1'b1, 32};
      vecs[5]  = '{1'b0, 1'b1, 32'h007fa509, 32'h00000000, 32'h007fa509, 1'b1, 1'b1, 1'b0, 13};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000000f, 32'h000000f0, 32'h000000ff, 1'b1, 1'b1, 1'b0, 8};
      vecs[7]  = '{1'b0, 1'b0, 32'h12345678, 32'hffff0000, 32'h000000ff, 1'b0, 1'b1, 1'b0, 8};
      vecs[8]  = '{1'b0, 1'b0, 32'hffffffff, 32'h00000000, 32'h000000ff, 1'b0, 1'b1, 1'b0, 8};
      vecs[9]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h000000ff, 1'b0, 1'b1, 1'b0, 8};
      vecs[10] = '{1'b1, 1'b1, 32'hffffffff, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 0};
      vecs[11] = '{1'b0, 1'b1, 32'h00000001, 32'h00000002, 32'h00000003, 1'b1, 1'b1, 1'b0, 2};
      vecs[12] = '{1'b0, 1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 1};
      vecs[13] = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 0};

      for (int i = 0; i < 14; i++) begin
         rst = vecs[i].rst; in_valid = vecs[i].iv; a = vecs[i].a; b = vecs[i].b;
         cycle();
         check_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].ov,
                   vecs[i].any, vecs[i].all, vecs[i].cnt);
      end

      // Narrow instance: reset state, then complementary operands fill every bit.
      check("w4.reset.c", longint'(c4), 64'd0);
      rst = 1'b0; in_valid = 1'b0;
      a4 = 4'b1010; b4 = 4'b0101; in_valid4 = 1'b1;
      cycle();
      check("w4.c",         longint'(c4),         64'hf);
      check("w4.all_set",   longint'(all_set4),   64'd1);
      check("w4.ones_cnt",  longint'(ones_cnt4),  64'd4);
      check("w4.out_valid", longint'(out_valid4), 64'd1);
      a4 = 4'b0100; b4 = 4'b0000; in_valid4 = 1'b1;
      cycle();
      check("w4b.c",        longint'(c4),         64'h4);
      check("w4b.all_set",  longint'(all_set4),   64'd0);
      check("w4b.ones_cnt", longint'(ones_cnt4),  64'd1);
      in_valid4 = 1'b0;
      cycle();
      check("w4hold.c",         longint'(c4),         64'h4);
      check("w4hold.out_valid", longint'(out_valid4), 64'd0);

      // Randomized traffic against a model of capture/hold/reset behaviour.
      rst = 1'b1; in_valid = 1'b0;
      cycle();
      m_c = 32'h0; m_ov = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rb;
         logic        rr, rv;
         int          sel;
         rr  = ($urandom_range(0, 19) == 0);
         rv  = ($urandom_range(0, 2) != 0);
         sel = $urandom_range(0, 5);
         ra  = $urandom();
         rb  = $urandom();
         if (sel == 0) begin
            ra = 32'hffffffff;
         end else if (sel == 1) begin
            ra = 32'h0; rb = 32'h0;
         end else if (sel == 2) begin
            rb = ~ra;
         end
         rst = rr; in_valid = rv; a = ra; b = rb;
         cycle();
         if (rr) begin
            m_c = 32'h0; m_ov = 1'b0;
         end else begin
            m_ov = rv;
            if (rv) m_c = ra | rb;
         end
         check_all($sformatf("rnd%0d", i), m_c, m_ov, m_c != 32'h0,
                   m_c == 32'hffffffff, $countones(m_c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
